// File: rtl/board_refill_pkg.sv
// Shared board geometry, colour/LFSR constants and FSM state type for the
// board refresh and match blocks.
package board_refill_pkg;

    localparam int BOARD_ROWS = 8;
    localparam int BOARD_COLS = 8;
    localparam int CELL_W     = 3;
    localparam int NUM_CELLS  = BOARD_ROWS * BOARD_COLS;
    localparam int BOARD_W    = NUM_CELLS * CELL_W;
    localparam int NUM_COLORS = 7;

    localparam logic [CELL_W-1:0] EMPTY     = 3'd0;
    localparam logic [15:0]       LFSR_TAPS = 16'hB400;
    localparam logic [15:0]       LFSR_ZERO_SUBST = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Next colour in 1..NUM_COLORS, skipping the empty code on wrap.
    function automatic logic [CELL_W-1:0] color_inc(input logic [CELL_W-1:0] c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

    // Candidate colour from the low six LFSR bits; never returns EMPTY.
    function automatic logic [CELL_W-1:0] lfsr_color(input logic [5:0] v);
        logic [CELL_W-1:0] c;
        c = 3'd1;
        if (v[2:0] != EMPTY)
            c = v[2:0];
        else if (v[5:3] != EMPTY)
            c = v[5:3];
        return c;
    endfunction

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] n;
        n = {1'b0, v[15:1]};
        if (v[0])
            n = n ^ LFSR_TAPS;
        return n;
    endfunction

endpackage

// File: rtl/board_refill_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and single-step advance.
module lfsr16
    import board_refill_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst)
            value <= SEED;
        else if (load)
            value <= load_val;
        else if (advance)
            value <= lfsr_step(value);
    end

endmodule

// File: rtl/board_refill.sv
// Refills the empty cells of a collapsed 8x8 board one cell per clock, using
// LFSR-derived colours nudged away from three-in-a-row matches.
module board_refill
    import board_refill_pkg::*;
#(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BOARD_W-1:0] board_in,
    input  logic [15:0]        seed,
    input  logic               seed_we,
    output logic               busy,
    output logic               done,
    output logic [BOARD_W-1:0] board_out,
    output logic [6:0]         filled_cnt
);

    state_t             state, state_nxt;
    logic [BOARD_W-1:0] work;
    logic [5:0]         idx;
    logic [6:0]         work_cnt;

    logic        lfsr_load;
    logic        lfsr_adv;
    logic [15:0] lfsr_load_val;
    logic [15:0] lfsr_val;
    logic        lfsr_hi_unused;

    logic [2:0]        row, col;
    logic [5:0]        idx_l1, idx_l2, idx_u1, idx_u2;
    logic [CELL_W-1:0] cur, left1, left2, up1, up2;
    logic [CELL_W-1:0] cand0, cand1, cand2;
    logic              left_hit, up_hit, fill;

    lfsr16 #(
        .SEED (SEED_DEFAULT)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .advance  (lfsr_adv),
        .value    (lfsr_val)
    );

    assign lfsr_hi_unused = ^lfsr_val[15:6];

    // Current cell and its neighbours; out-of-board indices are masked by row/col guards.
    always_comb begin
        row    = idx[5:3];
        col    = idx[2:0];
        idx_l1 = idx - 6'd1;
        idx_l2 = idx - 6'd2;
        idx_u1 = idx - 6'd8;
        idx_u2 = idx - 6'd16;
        cur    = work[CELL_W*idx    +: CELL_W];
        left1  = work[CELL_W*idx_l1 +: CELL_W];
        left2  = work[CELL_W*idx_l2 +: CELL_W];
        up1    = work[CELL_W*idx_u1 +: CELL_W];
        up2    = work[CELL_W*idx_u2 +: CELL_W];
    end

    // Candidate colour with left-then-above match avoidance, at most two bumps.
    always_comb begin
        cand0    = lfsr_color(lfsr_val[5:0]);
        left_hit = (col >= 3'd2) && (left1 == cand0) && (left2 == cand0);
        cand1    = left_hit ? color_inc(cand0) : cand0;
        up_hit   = (row >= 3'd2) && (up1 == cand1) && (up2 == cand1);
        cand2    = up_hit ? color_inc(cand1) : cand1;
        fill     = (state == SCAN) && (cur == EMPTY);
    end

    always_comb begin
        state_nxt     = state;
        lfsr_load     = 1'b0;
        lfsr_adv      = 1'b0;
        lfsr_load_val = (seed == 16'h0000) ? LFSR_ZERO_SUBST : seed;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                lfsr_load = seed_we;
                if (start)
                    state_nxt = SCAN;
            end
            SCAN: begin
                busy     = 1'b1;
                lfsr_adv = fill;
                if (idx == 6'd63)
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Working board, scan index and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            work       <= '0;
            idx        <= '0;
            work_cnt   <= '0;
            board_out  <= '0;
            filled_cnt <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work       <= board_in;
                        idx        <= '0;
                        work_cnt   <= '0;
                        filled_cnt <= '0;
                    end
                end
                SCAN: begin
                    if (fill) begin
                        work[CELL_W*idx +: CELL_W] <= cand2;
                        work_cnt <= work_cnt + 7'd1;
                    end
                    idx <= idx + 6'd1;
                end
                DONE: begin
                    board_out  <= work;
                    filled_cnt <= work_cnt;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_refill.sv
// Self-checking bench for board_refill: directed vector table, randomized boards
// against a grid-level reference model, and a reset-during-scan sequence.
module tb_board_refill;

    logic         clk = 1'b0;
    logic         rst, start, seed_we, busy, done;
    logic [15:0]  seed;
    logic [191:0] board_in, board_out;
    logic [6:0]   filled_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl_lfsr;

    always #5 clk = ~clk;

    board_refill dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .board_in   (board_in),
        .seed       (seed),
        .seed_we    (seed_we),
        .busy       (busy),
        .done       (done),
        .board_out  (board_out),
        .filled_cnt (filled_cnt)
    );

    typedef struct {
        logic [191:0] b;
        logic         sw;
        logic [15:0]  sd;
        bit           use_model;
        bit           noise;
        logic [191:0] eb;
        int           ec;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [191:0] put(input logic [191:0] b, input int r, input int c,
                                         input logic [2:0] v);
        b[(8*r+c)*3 +: 3] = v;
        return b;
    endfunction

    function automatic logic [191:0] fill_all(input logic [2:0] v);
        logic [191:0] b;
        for (int i = 0; i < 64; i++) b[i*3 +: 3] = v;
        return b;
    endfunction

    // Reference: walk the grid row-major, pick a colour from the LFSR, bump it
    // away from a left pair, then an upper pair, and step the LFSR per fill.
    task automatic model_refill(input logic [191:0] b, input logic [15:0] l_in,
                                output logic [191:0] ob, output int cnt,
                                output logic [15:0] l_out);
        int g[8][8];
        int l, cand;
        l = int'(l_in);
        cnt = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                g[r][c] = int'(b[(8*r+c)*3 +: 3]);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (g[r][c] == 0) begin
                    cand = l % 8;
                    if (cand == 0) cand = (l / 8) % 8;
                    if (cand == 0) cand = 1;
                    if (c >= 2 && g[r][c-1] == cand && g[r][c-2] == cand) cand = cand % 7 + 1;
                    if (r >= 2 && g[r-1][c] == cand && g[r-2][c] == cand) cand = cand % 7 + 1;
                    g[r][c] = cand;
                    cnt++;
                    if (l % 2 == 1) l = (l / 2) ^ 'hB400;
                    else            l = l / 2;
                end
            end
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                ob[(8*r+c)*3 +: 3] = 3'(g[r][c]);
        l_out = 16'(l);
    endtask

    task automatic chk_vec(input string nm, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Launch one pass and wait (bounded) for done; optionally poke start and
    // seed_we mid-scan, which must be ignored.
    task automatic run_pass(input logic [191:0] b, input logic sw, input logic [15:0] sd,
                            input bit noise, output logic [191:0] ob, output int oc,
                            output int lat, output logic bsy);
        @(negedge clk);
        board_in = b;
        seed_we  = sw;
        seed     = sd;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        seed_we = 1'b0;
        bsy     = busy;
        lat     = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (noise) begin
                start    = (k == 9);
                seed_we  = (k == 19);
                seed     = 16'h5A5A;
                board_in = ~b;
            end
        end
        start   = 1'b0;
        seed_we = 1'b0;
        ob = board_out;
        oc = int'(filled_cnt);
    endtask

    initial begin
        logic [191:0] b, ob, eb, mb;
        logic [15:0]  lnext;
        int oc, ec, mc, lat, zeros, fired;
        logic bsy;

        // Directed vectors
        vecs[0] = '{fill_all(3'd1), 1'b1, 16'h1234, 1'b0, 1'b0, fill_all(3'd1), 0};
        vecs[1] = '{fill_all(3'd0), 1'b0, 16'h0000, 1'b1, 1'b1, '0, 0};
        b = put(fill_all(3'd1), 0, 0, 3'd0);
        vecs[2] = '{b, 1'b1, 16'h0001, 1'b0, 1'b0, fill_all(3'd1), 1};
        b = put(put(put(fill_all(3'd1), 0, 0, 3'd5), 0, 1, 3'd5), 0, 2, 3'd0);
        vecs[3] = '{b, 1'b1, 16'h0005, 1'b0, 1'b0, put(b, 0, 2, 3'd6), 1};
        b = put(put(put(fill_all(3'd1), 0, 0, 3'd7), 0, 1, 3'd7), 0, 2, 3'd0);
        vecs[4] = '{b, 1'b1, 16'h0007, 1'b0, 1'b0, put(b, 0, 2, 3'd1), 1};
        vecs[5] = '{fill_all(3'd0), 1'b1, 16'hACE1, 1'b1, 1'b0, '0, 0};
        vecs[6] = '{fill_all(3'd0), 1'b1, 16'h0000, 1'b1, 1'b0, '0, 0};
        b = put(put(put(fill_all(3'd1), 0, 0, 3'd3), 1, 0, 3'd3), 2, 0, 3'd0);
        vecs[7] = '{b, 1'b1, 16'h0003, 1'b0, 1'b0, put(b, 2, 0, 3'd4), 1};
        b = put(put(fill_all(3'd1), 2, 0, 3'd5), 2, 1, 3'd5);
        b = put(put(put(b, 0, 2, 3'd6), 1, 2, 3'd6), 2, 2, 3'd0);
        vecs[8] = '{b, 1'b1, 16'h0005, 1'b0, 1'b0, put(b, 2, 2, 3'd7), 1};
        b = put(fill_all(3'd2), 0, 0, 3'd0);
        vecs[9]  = '{b, 1'b1, 16'h0028, 1'b0, 1'b0, put(b, 0, 0, 3'd5), 1};
        vecs[10] = '{b, 1'b1, 16'h0040, 1'b0, 1'b0, put(b, 0, 0, 3'd1), 1};

        rst = 1'b1; start = 1'b0; seed_we = 1'b0; seed = '0; board_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        chk_vec("reset_board_out", board_out, '0);
        chk_int("reset_filled_cnt", int'(filled_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        mdl_lfsr = 16'hACE1;

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].sw) mdl_lfsr = (vecs[i].sd == 16'h0000) ? 16'hACE1 : vecs[i].sd;
            model_refill(vecs[i].b, mdl_lfsr, mb, mc, lnext);
            mdl_lfsr = lnext;
            eb = vecs[i].use_model ? mb : vecs[i].eb;
            ec = vecs[i].use_model ? mc : vecs[i].ec;
            run_pass(vecs[i].b, vecs[i].sw, vecs[i].sd, vecs[i].noise, ob, oc, lat, bsy);
            chk_int($sformatf("vec%0d_busy", i), int'(bsy), 1);
            chk_int($sformatf("vec%0d_latency", i), lat, 65);
            chk_vec($sformatf("vec%0d_board", i), ob, eb);
            chk_int($sformatf("vec%0d_filled_cnt", i), oc, ec);
            @(posedge clk);
            #1;
            chk_int($sformatf("vec%0d_done_pulse", i), int'(done), 0);
            if (i == 5) begin
                zeros = 0;
                for (int c = 0; c < 64; c++) if (ob[c*3 +: 3] == 3'd0) zeros++;
                chk_int("all_zero_no_empty", zeros, 0);
                chk_int("all_zero_cnt64", oc, 64);
            end
        end

        // Randomized boards against the model
        for (int it = 0; it < 8; it++) begin
            logic sw;
            logic [15:0] sd;
            bit nz;
            for (int c = 0; c < 64; c++)
                b[c*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            sw = ($urandom_range(0, 2) == 0);
            sd = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            nz = ($urandom_range(0, 1) == 1);
            if (sw) mdl_lfsr = (sd == 16'h0000) ? 16'hACE1 : sd;
            model_refill(b, mdl_lfsr, mb, mc, lnext);
            mdl_lfsr = lnext;
            run_pass(b, sw, sd, nz, ob, oc, lat, bsy);
            chk_int($sformatf("rnd%0d_latency", it), lat, 65);
            chk_vec($sformatf("rnd%0d_board", it), ob, mb);
            chk_int($sformatf("rnd%0d_filled_cnt", it), oc, mc);
        end

        // Reset in the middle of a scan, with ignored start and seed_we before it
        @(negedge clk);
        board_in = fill_all(3'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        fired = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start   = (k == 10);
            seed_we = (k == 20);
            seed    = 16'h1357;
            rst     = (k == 30);
            @(posedge clk);
            #1;
            if (done) fired = 1;
            if (k == 15) chk_int("midscan_busy", int'(busy), 1);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; seed_we = 1'b0;
        chk_int("abort_busy", int'(busy), 0);
        chk_vec("abort_board_out", board_out, '0);
        chk_int("abort_filled_cnt", int'(filled_cnt), 0);
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            if (done) fired = 1;
        end
        chk_int("abort_no_done", fired, 0);
        mdl_lfsr = 16'hACE1;
        model_refill(fill_all(3'd0), mdl_lfsr, mb, mc, lnext);
        run_pass(fill_all(3'd0), 1'b0, 16'h0000, 1'b0, ob, oc, lat, bsy);
        chk_int("post_reset_latency", lat, 65);
        chk_vec("post_reset_board", ob, mb);
        chk_int("post_reset_filled_cnt", oc, mc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_refill.md
BOARD_REFILL -- requirements
Module: board_refill

Interface
REQ-001 The block SHALL have parameter SEED_DEFAULT, default 16'hACE1, meaning the LFSR value after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a refill of board_in; sampled in IDLE only.
REQ-005 The block SHALL have port board_in, input, 192 bits: the collapsed board.
  - Cell (row r, col c) sits at bits (8*r+c)*3 +: 3.
  - Row 0 is the top row; value 0 means empty.
REQ-006 The block SHALL have port seed, input, 16 bits: a new LFSR seed.
REQ-007 The block SHALL have port seed_we, input, 1 bit: load seed; honoured in IDLE only.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in SCAN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when board_out becomes valid.
REQ-010 The block SHALL have port board_out, output, 192 bits: the refilled board, same layout as board_in; held until the next accepted start.
REQ-011 The block SHALL have port filled_cnt, output, 7 bits: number of cells filled in the last refill, 0..64.

Function
REQ-012 The FSM SHALL have states IDLE, SCAN and DONE.
  - IDLE -> SCAN on start.
  - SCAN -> DONE after cell index 63.
  - DONE -> IDLE unconditionally.
REQ-013 On an accepted start, the block SHALL latch board_in into a working board, clear the cell index to 0 and clear filled_cnt to 0.
REQ-014 In SCAN, the block SHALL process exactly one cell per clock, in row-major order, indices 0..63.
REQ-015 A nonzero cell SHALL be left unchanged, and the LFSR SHALL NOT advance for it.
REQ-016 An empty cell SHALL be written with a candidate colour; the LFSR SHALL advance once and filled_cnt SHALL increment.
REQ-017 The candidate colour SHALL be chosen as follows:
  - lfsr[2:0] if that is nonzero;
  - else lfsr[5:3] if that is nonzero;
  - else 3'd1.
REQ-018 The LFSR SHALL be a 16-bit Galois LFSR.
  - Shift right; when the outgoing bit is 1, XOR with 16'hB400.
REQ-019 Match avoidance SHALL be applied in this order:
  - If the two working-board cells to the left (c-1, c-2) both equal the candidate, increment the candidate (7 wraps to 1).
  - Then, if the two cells above (r-1, r-2) both equal the result, increment it again with the same wrap.
  - Checks that would fall outside the board SHALL be skipped.
  - Exactly two increments at most; a residual match after both is permitted.
REQ-020 The neighbour checks SHALL use the working board, including cells filled earlier in the same pass.
REQ-021 Latency: with start accepted at edge T, done SHALL be high during the cycle after edge T+65, and board_out and filled_cnt SHALL update on that same edge.
REQ-022 start received while in SCAN or DONE SHALL be ignored, not queued.
REQ-023 seed_we received while in IDLE SHALL load seed into the LFSR; a seed value of 0 SHALL load 16'hACE1 instead.
REQ-024 If seed_we and start arrive in the same cycle, the new seed SHALL be the value used for the first filled cell.
REQ-025 seed_we received while in SCAN or DONE SHALL be ignored.
REQ-026 A board with no empty cells SHALL still take 64 SCAN cycles, then return board_out equal to board_in with filled_cnt 0 and the LFSR unchanged.

Reset
REQ-027 When rst is high at a clock edge, the block SHALL set:
  - state IDLE;
  - busy 0 and done 0;
  - board_out all zeros and filled_cnt 0;
  - LFSR to SEED_DEFAULT;
  - working board and cell index to 0.
REQ-028 rst SHALL take priority over start and seed_we; a reset during SCAN SHALL abandon the pass with no done pulse.

Structure
REQ-029 A shared package SHALL hold the following, for reuse by the refresh and match blocks:
  - BOARD_ROWS=8, BOARD_COLS=8, CELL_W=3, EMPTY=3'd0, NUM_COLORS=7;
  - LFSR_TAPS=16'hB400;
  - the FSM state enum.
REQ-030 The LFSR SHALL be a separate sub-module, lfsr16, with ports clk, rst, load, load_val, advance and value.

Verification
REQ-031 Reset, then a board of all ones with start -> done one cycle after edge T+65, board_out all ones, filled_cnt 0.
REQ-032 Seed 16'h0001 loaded, board with only cell 0 empty, start -> filled_cnt 1 and cell 0 equal to the colour derived from 16'h0001 per REQ-017/019, i.e. 3'd1.
REQ-033 All-zero board, seed 16'hACE1 -> filled_cnt 64, no zero cells, and the result matches the reference-model board from REQ-017..020.
REQ-034 Row 0 columns 0 and 1 = 5, cell (0,2) empty, LFSR forced to give candidate 5 -> cell (0,2) = 6; if the candidate is 7 and the neighbours are 7 -> result 1.
REQ-035 start pulsed again at T+10, seed_we pulsed at T+20, rst asserted at T+30 -> a single pass only until the reset, the seed stays unchanged, done never fires, and all outputs are zero after the reset.
